// File: rtl/voice_gate_decoder_pkg.sv
// Shared definitions for the voice-bus gate decoder: defaults, FSM encoding, counter sizing.
package voice_gate_decoder_pkg;

  localparam int unsigned VG_WIDTH     = 7;
  localparam int unsigned VG_PULSE_LEN = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } vg_state_e;

  // Bits needed to hold a pulse count of 0..len.
  function automatic int unsigned pulse_cw(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/voice_gate_decoder_idx_to_onehot.sv
// Combinational binary-index to one-hot decoder, shared by voice-bus consumers.
module idx_to_onehot #(
  parameter  int unsigned WIDTH = 7,
  localparam int unsigned LINES = 1 << WIDTH
) (
  input  logic [WIDTH-1:0] idx,
  output logic [LINES-1:0] out
);

  for (genvar i = 0; i < LINES; i++) begin : g_line
    assign out[i] = (idx == WIDTH'(i));
  end

endmodule

// File: rtl/voice_gate_decoder.sv
// Voice gate decoder: applies (index, on/off) events to a registered gate vector and
// fires a PULSE_LEN-cycle one-hot trigger on every accepted note-on.
module voice_gate_decoder
  import voice_gate_decoder_pkg::*;
#(
  parameter  int unsigned WIDTH     = VG_WIDTH,
  parameter  int unsigned PULSE_LEN = VG_PULSE_LEN,
  localparam int unsigned LINES     = 1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_idx,
  input  logic             in_on,
  input  logic             clear_all,
  output logic [LINES-1:0] gate,
  output logic [LINES-1:0] trig,
  output logic [WIDTH:0]   active_cnt
);

  localparam int unsigned PULSE_CW = pulse_cw(PULSE_LEN);
  localparam int unsigned CNT_W    = WIDTH + 1;

  vg_state_e            state_q, state_d;
  logic [PULSE_CW-1:0]  pcnt_q, pcnt_d;
  logic [LINES-1:0]     gate_q, gate_d;
  logic [LINES-1:0]     trig_q, trig_d;
  logic [CNT_W-1:0]     active_q, active_d;
  logic [LINES-1:0]     line_oh;
  logic                 accept;
  logic                 line_was_on;

  idx_to_onehot #(.WIDTH(WIDTH)) u_dec (
    .idx (in_idx),
    .out (line_oh)
  );

  // clear_all blocks acceptance in the same cycle it takes priority.
  assign in_ready    = (state_q == ST_IDLE) && !clear_all;
  assign accept      = in_valid && in_ready;
  assign line_was_on = gate_q[in_idx];

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    gate_d   = gate_q;
    trig_d   = trig_q;
    active_d = active_q;

    if (clear_all) begin
      state_d  = ST_IDLE;
      pcnt_d   = '0;
      gate_d   = '0;
      trig_d   = '0;
      active_d = '0;
    end else if (accept) begin
      if (in_on) begin
        gate_d  = gate_q | line_oh;
        trig_d  = line_oh;
        state_d = ST_PULSE;
        pcnt_d  = PULSE_CW'(PULSE_LEN - 1);
        if (!line_was_on) begin
          active_d = active_q + CNT_W'(1);
        end
      end else begin
        gate_d = gate_q & ~line_oh;
        if (line_was_on) begin
          active_d = active_q - CNT_W'(1);
        end
      end
    end else if (state_q == ST_PULSE) begin
      // Counter hits zero on the last pulse cycle; trigger drops on the following edge.
      if (pcnt_q == '0) begin
        state_d = ST_IDLE;
        trig_d  = '0;
      end else begin
        pcnt_d = pcnt_q - PULSE_CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pcnt_q   <= '0;
      gate_q   <= '0;
      trig_q   <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      gate_q   <= gate_d;
      trig_q   <= trig_d;
      active_q <= active_d;
    end
  end

  assign gate       = gate_q;
  assign trig       = trig_q;
  assign active_cnt = active_q;

endmodule
